operand_fetcher: RTL and testbench
==================================

Name: operand_fetcher

Overview:
- Sits directly downstream of the operand selection stage.
- On a start pulse (driven by select_done) it latches the selected matrix IDs, op type and their dimensions.
- It then reads every element of matrix A, and of matrix B when the op needs it, from the matrix storage RAM, row-major.
- Elements are streamed to the compute unit over a valid/ready interface, tagged with operand, row, column and last.

Parameters:
- DATA_W, 8, element width in bits.
- NUM_MAT, 10, number of matrix slots; sizes the meta vectors.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  one-cycle pulse; begin fetch. Ignored unless idle.
- abort  in  1  cancel the fetch in progress.
- id_a  in  4  matrix A slot ID.
- id_b  in  4  matrix B slot ID.
- op_type  in  3  000 transpose, 001 add, 010 scalar, 011 multiply, 100 conv.
- meta_m_flat  in  3*NUM_MAT  row count per slot, slot i at [i*3+:3].
- meta_n_flat  in  3*NUM_MAT  column count per slot, same packing.
- mem_rd_en  out  1  RAM read strobe.
- mem_rd_addr  out  10  {id[3:0], row[2:0], col[2:0]}.
- mem_rd_data  in  DATA_W  RAM data, valid exactly 1 cycle after mem_rd_en.
- out_valid  out  1  element available.
- out_ready  in  1  consumer accepts the element.
- out_data  out  DATA_W  element value.
- out_sel  out  1  0 = from A, 1 = from B.
- out_row  out  3  element row index.
- out_col  out  3  element column index.
- out_last  out  1  final element of the whole fetch.
- busy  out  1  high in every state except IDLE.
- fetch_done  out  1  one-cycle pulse on normal completion.
- fetch_error  out  1  one-cycle pulse on rejected start.

Behaviour:
- All state changes occur only on rising clk; reset is sampled synchronously.
- Reset (rst_n=0 at an edge):
  - state IDLE; every output 0; mem_rd_addr 0; internal counters 0.
  - This applies from any state: an in-flight read is discarded, out_valid drops.
- IDLE:
  - On start with id_a or id_b >= NUM_MAT (id_b checked only for two-operand ops): pulse fetch_error, stay IDLE.
  - On start where the latched dims of any needed operand have m==0 or n==0: pulse fetch_error, stay IDLE.
  - Otherwise latch ids, op_type, m_a, n_a, m_b, n_b; set sel=0, row=0, col=0; go to ISSUE.
  - two-operand op = add, multiply, conv. Transpose, scalar and undefined codes fetch A only.
- ISSUE:
  - mem_rd_en=1 for exactly this cycle, with mem_rd_addr={cur_id,row,col}.
  - cur_id = id_a when sel=0, id_b when sel=1. Go to WAIT.
- WAIT:
  - Register mem_rd_data into out_data, along with sel, row, col and the last flag.
  - Set out_valid=1; go to HOLD.
- HOLD:
  - out_valid and all payload outputs held stable while out_ready=0.
  - On a cycle with out_valid & out_ready, out_valid clears next cycle and the indices advance:
  - col+1 when col < n-1.
  - Otherwise col=0, row+1 when row < m-1.
  - Otherwise the operand is finished: switch to sel=1 at row=0, col=0 if the op is two-operand and sel==0; otherwise the fetch is complete.
  - Next state is ISSUE, or DONE if the fetch is complete.
  - m and n are those of the current operand.
- DONE: fetch_done=1 for one cycle; go to IDLE.
- out_last is 1 only on the final element: last of A for single-operand ops, last of B otherwise.
- Timing:
  - Minimum 3 cycles per element (ISSUE, WAIT, HOLD with out_ready=1).
  - Total with no backpressure: 3*(mA*nA + mB*nB) cycles from the first ISSUE, then 1 DONE cycle.
  - The first mem_rd_en occurs the cycle after start is accepted.
- Concurrency rules:
  - At most one read outstanding; never a new mem_rd_en while out_valid=1.
- abort (any non-IDLE state):
  - Next cycle: state IDLE, out_valid=0, mem_rd_en=0, no fetch_done.
  - Any returning read data is ignored.
  - abort in IDLE has no effect and has priority over a simultaneous start.
- start while busy=1 is ignored; inputs are not re-latched.
- id_a and id_b may be equal; the same slot is fetched twice.
- No dimension compatibility check; the upstream selector guarantees it.
- Meta inputs are sampled only at start acceptance; later changes have no effect.

Test Plan:
- Add, slot 1 = 2x3, slot 2 = 2x3, out_ready=1 → 12 elements.
  - A addresses 0x040,0x041,0x042,0x048,0x049,0x04A; B 0x080..0x08A, same pattern.
  - out_last only on B(1,2); fetch_done exactly 37 cycles after start.
- Transpose, slot 3 = 1x2, id_b=15 → no error (B unused).
  - 2 elements: addr 0x0C0, 0x0C1; out_sel=0; out_last on 2nd.
- Multiply, A 2x2, B 2x1, out_ready low 5 cycles on the 2nd element.
  - out_data/row/col stable throughout; no mem_rd_en until accepted.
  - Order: A(0,0),A(0,1),A(1,0),A(1,1),B(0,0),B(1,0).
- start with id_a=12, or with the needed slot's m=0 → fetch_error pulse; busy stays 0; no mem_rd_en.
- abort during the 3rd element's WAIT → next cycle busy=0, out_valid=0, no fetch_done.
  - A fresh start then begins again from A(0,0).
- rst_n=0 for one edge mid-HOLD → all outputs 0 next cycle.
  - A start pulse during busy (non-reset run) leaves the sequence unchanged.

Source files
------------

// File: rtl/operand_fetcher.sv
// Operand fetcher: streams matrix A (and B for two-operand ops) from the matrix
// RAM to the compute unit in row-major order, keeping at most one read in flight.
module operand_fetcher #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned NUM_MAT = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [3:0]             id_a,
  input  logic [3:0]             id_b,
  input  logic [2:0]             op_type,
  input  logic [3*NUM_MAT-1:0]   meta_m_flat,
  input  logic [3*NUM_MAT-1:0]   meta_n_flat,
  output logic                   mem_rd_en,
  output logic [9:0]             mem_rd_addr,
  input  logic [DATA_W-1:0]      mem_rd_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_sel,
  output logic [2:0]             out_row,
  output logic [2:0]             out_col,
  output logic                   out_last,
  output logic                   busy,
  output logic                   fetch_done,
  output logic                   fetch_error
);

  localparam int unsigned ID_W  = 4;
  localparam int unsigned IDX_W = 3;
  localparam logic [ID_W-1:0] NUM_MAT_ID = ID_W'(NUM_MAT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_DONE
  } state_t;

  // Out-of-range slot IDs read back as a 0 dimension.
  function automatic logic [IDX_W-1:0] dim_of(input logic [3*NUM_MAT-1:0] flat,
                                              input logic [ID_W-1:0] id);
    logic [IDX_W-1:0] dim;
    dim = '0;
    for (int unsigned i = 0; i < NUM_MAT; i++) begin
      if (id == ID_W'(i)) dim = flat[i*IDX_W +: IDX_W];
    end
    return dim;
  endfunction

  function automatic logic is_two_op(input logic [2:0] op);
    return (op == 3'b001) || (op == 3'b011) || (op == 3'b100);
  endfunction

  state_t           state;
  logic [ID_W-1:0]  id_a_q, id_b_q;
  logic             two_q;
  logic [IDX_W-1:0] m_a_q, n_a_q, m_b_q, n_b_q;
  logic             sel;
  logic [IDX_W-1:0] row, col;

  logic [IDX_W-1:0] req_m_a, req_n_a, req_m_b, req_n_b;
  logic             req_two, start_ok;

  always_comb begin
    req_m_a  = dim_of(meta_m_flat, id_a);
    req_n_a  = dim_of(meta_n_flat, id_a);
    req_m_b  = dim_of(meta_m_flat, id_b);
    req_n_b  = dim_of(meta_n_flat, id_b);
    req_two  = is_two_op(op_type);
    start_ok = (id_a < NUM_MAT_ID) && (req_m_a != '0) && (req_n_a != '0);
    if (req_two) begin
      start_ok = start_ok && (id_b < NUM_MAT_ID) && (req_m_b != '0) && (req_n_b != '0);
    end
  end

  logic [IDX_W-1:0] m_cur, n_cur;
  logic             nxt_sel, nxt_done, last_elem;
  logic [IDX_W-1:0] nxt_row, nxt_col;

  // Row-major index walk over the current operand, then hand over to B.
  always_comb begin
    m_cur     = sel ? m_b_q : m_a_q;
    n_cur     = sel ? n_b_q : n_a_q;
    nxt_sel   = sel;
    nxt_row   = row;
    nxt_col   = col;
    nxt_done  = 1'b0;
    if (col != n_cur - IDX_W'(1)) begin
      nxt_col = col + IDX_W'(1);
    end else begin
      nxt_col = '0;
      if (row != m_cur - IDX_W'(1)) begin
        nxt_row = row + IDX_W'(1);
      end else begin
        nxt_row = '0;
        if (two_q && !sel) nxt_sel = 1'b1;
        else               nxt_done = 1'b1;
      end
    end
    last_elem = (col == n_cur - IDX_W'(1)) && (row == m_cur - IDX_W'(1)) && (sel || !two_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_sel     <= 1'b0;
      out_row     <= '0;
      out_col     <= '0;
      out_last    <= 1'b0;
      fetch_done  <= 1'b0;
      fetch_error <= 1'b0;
      id_a_q      <= '0;
      id_b_q      <= '0;
      two_q       <= 1'b0;
      m_a_q       <= '0;
      n_a_q       <= '0;
      m_b_q       <= '0;
      n_b_q       <= '0;
      sel         <= 1'b0;
      row         <= '0;
      col         <= '0;
    end else begin
      mem_rd_en   <= 1'b0;
      fetch_done  <= 1'b0;
      fetch_error <= 1'b0;
      if (state != S_IDLE && abort) begin
        // Any read still in flight is simply never captured.
        state     <= S_IDLE;
        busy      <= 1'b0;
        out_valid <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !abort) begin
              if (!start_ok) begin
                fetch_error <= 1'b1;
              end else begin
                id_a_q      <= id_a;
                id_b_q      <= id_b;
                two_q       <= req_two;
                m_a_q       <= req_m_a;
                n_a_q       <= req_n_a;
                m_b_q       <= req_m_b;
                n_b_q       <= req_n_b;
                sel         <= 1'b0;
                row         <= '0;
                col         <= '0;
                mem_rd_en   <= 1'b1;
                mem_rd_addr <= {id_a, IDX_W'(0), IDX_W'(0)};
                busy        <= 1'b1;
                state       <= S_ISSUE;
              end
            end
          end
          S_ISSUE: state <= S_WAIT;
          S_WAIT: begin
            out_data  <= mem_rd_data;
            out_sel   <= sel;
            out_row   <= row;
            out_col   <= col;
            out_last  <= last_elem;
            out_valid <= 1'b1;
            state     <= S_HOLD;
          end
          S_HOLD: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              sel       <= nxt_sel;
              row       <= nxt_row;
              col       <= nxt_col;
              if (nxt_done) begin
                fetch_done <= 1'b1;
                state      <= S_DONE;
              end else begin
                mem_rd_en   <= 1'b1;
                mem_rd_addr <= {(nxt_sel ? id_b_q : id_a_q), nxt_row, nxt_col};
                state       <= S_ISSUE;
              end
            end
          end
          S_DONE: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: begin
            busy      <= 1'b0;
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_operand_fetcher.sv
// Bench for operand_fetcher: directed and random fetches against an element-list
// model of the row-major walk and a random-content RAM.
module tb_operand_fetcher;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned NUM_MAT = 10;

  logic                 clk = 1'b0;
  logic                 rst_n, start, abort, out_ready;
  logic [3:0]           id_a, id_b;
  logic [2:0]           op_type;
  logic [3*NUM_MAT-1:0] meta_m_flat, meta_n_flat;
  logic                 mem_rd_en;
  logic [9:0]           mem_rd_addr;
  logic [DATA_W-1:0]    mem_rd_data;
  logic                 out_valid, out_sel, out_last, busy, fetch_done, fetch_error;
  logic [DATA_W-1:0]    out_data;
  logic [2:0]           out_row, out_col;

  operand_fetcher #(.DATA_W(DATA_W), .NUM_MAT(NUM_MAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .id_a(id_a), .id_b(id_b), .op_type(op_type),
    .meta_m_flat(meta_m_flat), .meta_n_flat(meta_n_flat),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sel(out_sel), .out_row(out_row), .out_col(out_col), .out_last(out_last),
    .busy(busy), .fetch_done(fetch_done), .fetch_error(fetch_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] addr;
    logic       sel;
    logic [2:0] row;
    logic [2:0] col;
    logic       last;
  } elem_t;

  elem_t       exp_q[$];
  logic [2:0]  tb_m[NUM_MAT];
  logic [2:0]  tb_n[NUM_MAT];
  logic [7:0]  ram[1024];
  int          errors = 0;
  int          checks = 0;

  always_comb begin
    meta_m_flat = '0;
    meta_n_flat = '0;
    for (int i = 0; i < NUM_MAT; i++) begin
      meta_m_flat[i*3 +: 3] = tb_m[i];
      meta_n_flat[i*3 +: 3] = tb_n[i];
    end
  end

  // RAM model: one-cycle read latency, garbage on idle cycles.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];
    else           mem_rd_data <= 8'($urandom);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs_word();
    return 32'({mem_rd_en, mem_rd_addr, out_valid, out_data, out_sel, out_row,
                out_col, out_last, busy, fetch_done, fetch_error});
  endfunction

  // Expected element sequence: A row-major, then B for add/multiply/conv.
  function automatic void build(input logic [3:0] ida, input logic [3:0] idb, input logic [2:0] op);
    int         nops;
    logic [3:0] id;
    elem_t      e;
    exp_q.delete();
    nops = (op == 3'd1 || op == 3'd3 || op == 3'd4) ? 2 : 1;
    for (int s = 0; s < nops; s++) begin
      id = (s == 0) ? ida : idb;
      for (int r = 0; r < int'(tb_m[id]); r++) begin
        for (int c = 0; c < int'(tb_n[id]); c++) begin
          e.addr = {id, 3'(r), 3'(c)};
          e.sel  = 1'(s);
          e.row  = 3'(r);
          e.col  = 3'(c);
          e.last = (s == nops - 1) && (r == int'(tb_m[id]) - 1) && (c == int'(tb_n[id]) - 1);
          exp_q.push_back(e);
        end
      end
    end
  endfunction

  task automatic run_fetch(input logic [3:0] ida, input logic [3:0] idb, input logic [2:0] op,
                           input int stall_idx, input bit rnd_rdy, input int abort_iss,
                           input int reset_acc, input bit inject_start, input bit chk_time);
    int    iss, acc, cyc, stall, total;
    bit    done;
    elem_t e;
    build(ida, idb, op);
    total = exp_q.size();
    iss = 0; acc = 0; cyc = 0; stall = 0; done = 1'b0;
    @(negedge clk);
    id_a = ida; id_b = idb; op_type = op; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    for (int i = 0; i < NUM_MAT; i++) begin
      tb_m[i] = 3'($urandom);
      tb_n[i] = 3'($urandom);
    end
    while (!done && cyc < 40 * total + 40) begin
      chk("busy", 32'(busy), 32'd1);
      if (mem_rd_en) begin
        chk("rd_while_valid", 32'(out_valid), 32'd0);
        if (iss < total) chk("rd_addr", 32'(mem_rd_addr), 32'(exp_q[iss].addr));
        else             chk("rd_count", 32'(iss), 32'(total - 1));
        iss++;
        if (iss == abort_iss + 1) begin
          @(negedge clk);
          abort = 1'b1;
          @(negedge clk);
          abort = 1'b0;
          chk("abort_idle", 32'({busy, out_valid, mem_rd_en, fetch_done}), 32'd0);
          repeat (4) begin
            @(negedge clk);
            chk("abort_quiet", 32'({busy, out_valid, mem_rd_en, fetch_done}), 32'd0);
          end
          return;
        end
      end
      if (fetch_done) begin
        chk("done_count", 32'(acc), 32'(total));
        if (chk_time) chk("done_cycle", 32'(cyc), 32'(3 * total + 1));
        done = 1'b1;
      end else if (out_valid) begin
        if (acc == reset_acc) begin
          rst_n = 1'b0;
          @(negedge clk);
          rst_n = 1'b1;
          chk("reset_outs", outs_word(), 32'd0);
          return;
        end
        if (acc < total) begin
          e = exp_q[acc];
          chk("payload", 32'({out_data, out_sel, out_row, out_col, out_last}),
              32'({ram[e.addr], e.sel, e.row, e.col, e.last}));
        end else begin
          chk("out_count", 32'(acc), 32'(total - 1));
        end
        if (acc == stall_idx && stall < 5) begin
          out_ready = 1'b0;
          stall++;
        end else begin
          out_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        if (out_ready) acc++;
      end else begin
        out_ready = rnd_rdy ? ($urandom_range(0, 1) != 0) : 1'b1;
      end
      start = inject_start && (cyc == 10);
      if (start) id_a = 4'(ida + 4'd1);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("timeout", 32'(done), 32'd1);
    chk("idle_after", 32'({fetch_done, busy}), 32'd0);
  endtask

  task automatic reject(input string tag, input logic [3:0] ida, input logic [3:0] idb,
                        input logic [2:0] op);
    @(negedge clk);
    id_a = ida; id_b = idb; op_type = op; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_err"}, 32'(fetch_error), 32'd1);
    chk({tag, "_quiet"}, 32'({busy, mem_rd_en, out_valid}), 32'd0);
    @(negedge clk);
    chk({tag, "_after"}, 32'({fetch_error, busy, mem_rd_en}), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    id_a = '0; id_b = '0; op_type = '0;
    for (int i = 0; i < 1024; i++) ram[i] = 8'($urandom);
    for (int i = 0; i < NUM_MAT; i++) begin
      tb_m[i] = '0;
      tb_n[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk("reset_state", outs_word(), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_state", outs_word(), 32'd0);

    // Add 2x3 + 2x3, with a stray start while busy
    tb_m[1] = 3'd2; tb_n[1] = 3'd3; tb_m[2] = 3'd2; tb_n[2] = 3'd3;
    run_fetch(4'd1, 4'd2, 3'd1, -1, 1'b0, -1, -1, 1'b1, 1'b1);

    // Transpose 1x2 with an out-of-range but unused B slot
    tb_m[3] = 3'd1; tb_n[3] = 3'd2;
    run_fetch(4'd3, 4'd15, 3'd0, -1, 1'b0, -1, -1, 1'b0, 1'b1);

    // Multiply 2x2 by 2x1, consumer stalls on the 2nd element
    tb_m[4] = 3'd2; tb_n[4] = 3'd2; tb_m[5] = 3'd2; tb_n[5] = 3'd1;
    run_fetch(4'd4, 4'd5, 3'd3, 1, 1'b0, -1, -1, 1'b0, 1'b0);

    // Rejected starts
    tb_m[1] = 3'd2; tb_n[1] = 3'd3;
    reject("bad_id_a", 4'd12, 4'd1, 3'd1);
    tb_m[6] = 3'd0; tb_n[6] = 3'd3;
    reject("zero_m", 4'd6, 4'd0, 3'd0);
    tb_m[1] = 3'd2; tb_n[1] = 3'd3;
    reject("bad_id_b", 4'd1, 4'd13, 3'd1);
    tb_m[1] = 3'd2; tb_n[1] = 3'd3; tb_m[5] = 3'd2; tb_n[5] = 3'd0;
    reject("zero_nb", 4'd1, 4'd5, 3'd3);

    // Abort during the 3rd element's WAIT, then a clean restart
    tb_m[1] = 3'd2; tb_n[1] = 3'd3; tb_m[2] = 3'd2; tb_n[2] = 3'd3;
    run_fetch(4'd1, 4'd2, 3'd1, -1, 1'b0, 2, -1, 1'b0, 1'b0);
    tb_m[1] = 3'd2; tb_n[1] = 3'd3; tb_m[2] = 3'd2; tb_n[2] = 3'd3;
    run_fetch(4'd1, 4'd2, 3'd1, -1, 1'b0, -1, -1, 1'b0, 1'b1);

    // Abort in IDLE wins over a simultaneous start
    tb_m[1] = 3'd2; tb_n[1] = 3'd3;
    @(negedge clk);
    id_a = 4'd1; op_type = 3'd0; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("idle_abort", 32'({busy, mem_rd_en, fetch_error}), 32'd0);

    // Reset mid-HOLD, then a clean run
    tb_m[7] = 3'd2; tb_n[7] = 3'd2; tb_m[8] = 3'd3; tb_n[8] = 3'd1;
    run_fetch(4'd7, 4'd8, 3'd4, -1, 1'b0, -1, 3, 1'b0, 1'b0);
    tb_m[7] = 3'd2; tb_n[7] = 3'd2; tb_m[8] = 3'd3; tb_n[8] = 3'd1;
    run_fetch(4'd7, 4'd8, 3'd4, -1, 1'b0, -1, -1, 1'b0, 1'b1);

    // Same slot as both operands
    tb_m[9] = 3'd2; tb_n[9] = 3'd2;
    run_fetch(4'd9, 4'd9, 3'd1, -1, 1'b0, -1, -1, 1'b0, 1'b1);

    // Random dims, slots, ops and backpressure
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < NUM_MAT; i++) begin
        tb_m[i] = 3'($urandom_range(1, 7));
        tb_n[i] = 3'($urandom_range(1, 7));
      end
      run_fetch(4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 3'($urandom_range(0, 7)),
                -1, 1'b1, -1, -1, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
